// File: rtl/serial_det_scheduler.sv
// Round-robin scheduler sharing one bit-serial sequence detector between
// N_REQ requesters: grant, clear detector, shift word MSB-first, count
// detector hits, report the count tagged with the requester id.
module serial_det_scheduler #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   word_in,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      det_clear,
    output logic                      det_valid,
    output logic                      det_bit,
    input  logic                      det_F,
    output logic                      done,
    output logic [$clog2(N_REQ)-1:0]  done_id,
    output logic [CNT_W-1:0]          match_count
);

    localparam int IDW = $clog2(N_REQ);
    localparam int BCW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BCW-1:0]     bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    // Arms the arbiter one edge after reset release, so grant stays low
    // while reset is held even though the FSM sits in IDLE.
    logic               en_q;

    logic [IDW-1:0]     win;
    logic               found;
    logic               hit;

    // Rotating-priority pick: first set req scanning from last+1, wrapping.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Saturating hit: count det_F only while the counter has headroom.
    assign hit = det_F && (mcnt_q != {CNT_W{1'b1}});

    // Next-state and datapath updates for the grant/clear/shift/drain/report cycle.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        mcnt_d        = mcnt_q;
        done_id_d     = done_id_q;
        match_count_d = match_count_q;
        case (state_q)
            IDLE: begin
                if (en_q && found) begin
                    shreg_d = word_in[win*WORD_W +: WORD_W];
                    last_d  = win;
                    id_d    = win;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bitcnt_d = '0;
                mcnt_d   = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + BCW'(1);
                // First shift cycle's det_F still reflects the cleared detector.
                if (bitcnt_q != '0 && hit)
                    mcnt_d = mcnt_q + CNT_W'(1);
                if (bitcnt_q == BCW'(WORD_W - 1))
                    state_d = DRAIN;
            end
            DRAIN: begin
                // Final bit's response arrives here; fold it straight into the result.
                match_count_d = hit ? mcnt_q + CNT_W'(1) : mcnt_q;
                done_id_d     = id_q;
                state_d       = REPORT;
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_q        <= IDW'(N_REQ - 1);
            id_q          <= '0;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            mcnt_q        <= '0;
            done_id_q     <= '0;
            match_count_q <= '0;
            en_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            id_q          <= id_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            mcnt_q        <= mcnt_d;
            done_id_q     <= done_id_d;
            match_count_q <= match_count_d;
            en_q          <= 1'b1;
        end
    end

    // One-hot grant pulse in the IDLE cycle that commits the winner.
    always_comb begin
        grant = '0;
        if (state_q == IDLE && en_q && found)
            grant[win] = 1'b1;
    end

    assign busy        = (state_q != IDLE);
    assign det_clear   = (state_q == CLEAR);
    assign det_valid   = (state_q == SHIFT);
    assign det_bit     = (state_q == SHIFT) && shreg_q[WORD_W-1];
    assign done        = (state_q == REPORT);
    assign done_id     = done_id_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_serial_det_scheduler.sv
// Bench for serial_det_scheduler: default instance plus a CNT_W=2 instance
// for saturation, each driving a Moore "11" detector model.
module tb_serial_det_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] word_in = '0;
    logic [N-1:0]   grant;
    logic           busy, det_clear, det_valid, det_bit, det_F, done;
    logic [1:0]     done_id;
    logic [3:0]     match_count;

    logic [N-1:0]   req_s = '0;
    logic [N*W-1:0] word_s = '0;
    logic [N-1:0]   grant_s;
    logic           busy_s, det_clear_s, det_valid_s, det_bit_s, det_F_s, done_s;
    logic [1:0]     done_id_s;
    logic [1:0]     match_count_s;

    logic [1:0]     hist, hist_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_m = N - 1;

    serial_det_scheduler #(.N_REQ(N), .WORD_W(W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .req(req), .word_in(word_in),
        .grant(grant), .busy(busy), .det_clear(det_clear), .det_valid(det_valid),
        .det_bit(det_bit), .det_F(det_F), .done(done), .done_id(done_id),
        .match_count(match_count)
    );

    serial_det_scheduler #(.N_REQ(N), .WORD_W(W), .CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .req(req_s), .word_in(word_s),
        .grant(grant_s), .busy(busy_s), .det_clear(det_clear_s), .det_valid(det_valid_s),
        .det_bit(det_bit_s), .det_F(det_F_s), .done(done_s), .done_id(done_id_s),
        .match_count(match_count_s)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Detector models: F=1 when the last two valid bits were 1,1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         hist <= '0;
        else if (det_clear) hist <= '0;
        else if (det_valid) hist <= {hist[0], det_bit};
    end
    assign det_F = &hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           hist_s <= '0;
        else if (det_clear_s) hist_s <= '0;
        else if (det_valid_s) hist_s <= {hist_s[0], det_bit_s};
    end
    assign det_F_s = &hist_s;

    // Reference: matches = number of adjacent "11" pairs in the word.
    function automatic int pairs11(logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < W - 1; i++) if (w[i] && w[i+1]) c++;
        return c;
    endfunction

    function automatic int sat(int c, int cw);
        int mx = (1 << cw) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        req = '1;
        word_in = $urandom();
        repeat (2) @(negedge clock);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || det_clear !== 1'b0 || det_valid !== 1'b0 || det_bit !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: busy=%b done=%b clr=%b vld=%b bit=%b want all 0", busy, done, det_clear, det_valid, det_bit); end
        checks++; if (match_count !== 4'd0 || done_id !== 2'd0) begin
            errors++; $display("FAIL reset_result: mc=%0d id=%0d want 0 0", match_count, done_id); end
        reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_release_grant: got %b want 0000 before edge", grant); end
        @(negedge clock);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
        req = '0;
        last_m = N - 1;
    endtask

    task automatic test_single();
        logic [W-1:0] w = 8'b1110_0111;
        @(negedge clock);
        word_in = $urandom();
        word_in[2*W +: W] = w;
        req = 4'b0100;
        #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
        @(negedge clock);
        req = '0;
        checks++; if (det_clear !== 1'b1 || busy !== 1'b1 || det_valid !== 1'b0) begin
            errors++; $display("FAIL single_clear: clr=%b busy=%b vld=%b want 1 1 0", det_clear, busy, det_valid); end
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            checks++; if (det_valid !== 1'b1 || det_bit !== w[W-1-i] || det_clear !== 1'b0) begin
                errors++; $display("FAIL single_shift%0d: vld=%b bit=%b want 1 %b", i, det_valid, det_bit, w[W-1-i]); end
        end
        @(negedge clock);
        checks++; if (det_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL single_drain: vld=%b busy=%b done=%b want 0 1 0", det_valid, busy, done); end
        @(negedge clock);
        checks++; if (done !== 1'b1 || done_id !== 2'd2 || match_count !== sat(pairs11(w), 4)) begin
            errors++; $display("FAIL single_done: done=%b id=%0d mc=%0d want 1 2 %0d", done, done_id, match_count, sat(pairs11(w), 4)); end
        @(negedge clock);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || match_count !== 4'd4) begin
            errors++; $display("FAIL single_after: done=%b busy=%b mc=%0d want 0 0 4", done, busy, match_count); end
        last_m = 2;
    endtask

    task automatic test_hold();
        int n;
        logic [W-1:0] w = 8'h3C;
        @(negedge clock);
        word_in = $urandom();
        word_in[W +: W] = w;
        req = 4'b0010;
        #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b want 0010", grant); end
        @(negedge clock);
        req = '0;
        word_in = ~word_in;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++; if (done !== 1'b1 || done_id !== 2'd1 || match_count !== sat(pairs11(w), 4)) begin
            errors++; $display("FAIL hold_done: done=%b id=%0d mc=%0d want 1 1 %0d", done, done_id, match_count, sat(pairs11(w), 4)); end
        @(negedge clock);
        word_in[0 +: W] = 8'hFF;
        req = 4'b0001;
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL hold_grant2: got %b want 0001", grant); end
        @(negedge clock);
        req = '0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            checks++; if (match_count !== 4'd3 || done_id !== 2'd1) begin
                errors++; $display("FAIL hold_stable: mc=%0d id=%0d want 3 1", match_count, done_id); end
            @(negedge clock); n++;
        end
        checks++; if (done !== 1'b1 || done_id !== 2'd0 || match_count !== 4'd7) begin
            errors++; $display("FAIL hold_done2: done=%b id=%0d mc=%0d want 1 0 7", done, done_id, match_count); end
        @(negedge clock);
        last_m = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W-1:0] w = 8'hB6;
        @(negedge clock);
        word_in[3*W +: W] = w;
        req = 4'b1000;
        #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b want 1000", grant); end
        repeat (5) @(negedge clock);
        checks++; if (det_valid !== 1'b1) begin errors++; $display("FAIL rmid_inshift: vld=%b want 1", det_valid); end
        reset = 1'b0;
        #1;
        checks++; if ({grant, busy, det_clear, det_valid, det_bit, done} !== '0) begin
            errors++; $display("FAIL rmid_async: grant=%b busy=%b clr=%b vld=%b bit=%b done=%b want all 0",
                               grant, busy, det_clear, det_valid, det_bit, done); end
        checks++; if (match_count !== 4'd0 || done_id !== 2'd0) begin
            errors++; $display("FAIL rmid_result: mc=%0d id=%0d want 0 0", match_count, done_id); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rmid_held%0d: done=%b busy=%b want 0 0", i, done, busy); end
        end
        reset = 1'b1;
        last_m = N - 1;
        @(negedge clock);
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rmid_regrant: got %b want 1000", grant); end
        last_m = 3;
        @(negedge clock);
        req = '0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++; if (done !== 1'b1 || done_id !== 2'd3 || match_count !== sat(pairs11(w), 4)) begin
            errors++; $display("FAIL rmid_done: done=%b id=%0d mc=%0d want 1 3 %0d", done, done_id, match_count, sat(pairs11(w), 4)); end
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int n, prev, e;
        logic [N-1:0] eg;
        @(negedge clock);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        last_m = N - 1;
        word_in = '0;
        req = '1;
        @(negedge clock);
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (grant === '0 && n < 20) begin @(negedge clock); n++; end
            e = rr_pick(req, last_m);
            eg = '0;
            eg[e] = 1'b1;
            checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, grant, eg); end
            if (prev >= 0) begin
                checks++; if (cyc - prev != 12) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 12", k, cyc - prev); end
            end
            prev = cyc;
            last_m = e;
            @(negedge clock);
            n = 0;
            while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
            checks++; if (done !== 1'b1 || done_id !== 2'(e) || match_count !== 4'd0) begin
                errors++; $display("FAIL rr_done%0d: done=%b id=%0d mc=%0d want 1 %0d 0", k, done, done_id, match_count, e); end
            @(negedge clock);
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clock);
        word_s = '0;
        word_s[0 +: W] = 8'hFF;
        req_s = 4'b0001;
        #1;
        checks++; if (grant_s !== 4'b0001) begin errors++; $display("FAIL sat_grant: got %b want 0001", grant_s); end
        @(negedge clock);
        req_s = '0;
        n = 0;
        while (done_s !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++; if (done_s !== 1'b1 || done_id_s !== 2'd0 || match_count_s !== sat(pairs11(8'hFF), 2)) begin
            errors++; $display("FAIL sat_done: done=%b id=%0d mc=%0d want 1 0 %0d", done_s, done_id_s, match_count_s, sat(7, 2)); end
        @(negedge clock);
    endtask

    task automatic test_random();
        int e, g;
        logic [W-1:0] w;
        logic [N-1:0] eg;
        for (int t = 0; t < 25; t++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            word_in = $urandom();
            #1;
            e = rr_pick(req, last_m);
            w = word_in[e*W +: W];
            eg = '0;
            eg[e] = 1'b1;
            checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant%0d: got %b want %b (req %b)", t, grant, eg, req); end
            last_m = e;
            g = cyc;
            @(negedge clock);
            req = N'($urandom_range(0, (1 << N) - 1));
            word_in = $urandom();
            checks++; if (det_clear !== 1'b1) begin errors++; $display("FAIL rnd_clear%0d: got %b want 1", t, det_clear); end
            for (int i = 0; i < W; i++) begin
                @(negedge clock);
                checks++; if (det_valid !== 1'b1 || det_bit !== w[W-1-i]) begin
                    errors++; $display("FAIL rnd_bit%0d_%0d: vld=%b bit=%b want 1 %b", t, i, det_valid, det_bit, w[W-1-i]); end
            end
            repeat (2) @(negedge clock);
            checks++; if (done !== 1'b1 || done_id !== 2'(e) || match_count !== sat(pairs11(w), 4) || cyc - g != 11) begin
                errors++; $display("FAIL rnd_done%0d: done=%b id=%0d mc=%0d lat=%0d want 1 %0d %0d 11",
                                   t, done, done_id, match_count, cyc - g, e, sat(pairs11(w), 4)); end
            @(negedge clock);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_reset_mid();
        test_round_robin();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
